// File: rtl/shared_timer_sched.sv
// Round-robin scheduler sharing one preset-and-count-to-all-ones interval timer
// between two requesters; returns a one-cycle done pulse to the granted side.
module shared_timer_sched #(
    parameter int WIDTH = 8
) (
    input  logic             CP,
    input  logic             CR,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             tick,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic [1:0]       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Handshake: req[g] must stay high from grant until done[g] pulses (or the
    // interval is aborted); dropping it early while granted cancels the interval.

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;

    logic             g_idx;
    logic             cancel;
    logic             pick;

    assign g_idx  = gnt_q[1];
    assign cancel = abort | ~req[g_idx];
    // On a tie the requester that was not served last wins.
    assign pick   = (req == 2'b11) ? ~rr_q : req[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_d = S_LOAD;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    len_d   = pick ? len1 : len0;
                end
            end
            S_LOAD: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                end else begin
                    // Preset so that exactly len ticks reach the all-ones terminal count and wrap.
                    cnt_d   = '0 - len_q;
                    state_d = (len_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                rr_d    = g_idx;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            len_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != S_IDLE);
    assign cnt  = cnt_q;
    assign done = (state_q == S_DONE) ? gnt_q : 2'b00;

endmodule

// File: tb/tb_shared_timer_sched.sv
// Directed bench for shared_timer_sched (WIDTH=8): reset, single interval,
// round-robin ties, tick gating, abort paths, zero/one-length intervals.
module tb_shared_timer_sched;

    logic       CP;
    logic       CR;
    logic [1:0] req;
    logic [7:0] len0;
    logic [7:0] len1;
    logic       tick;
    logic       abort;
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] cnt;
    logic [1:0] done;

    int n_cmp;
    int n_err;

    shared_timer_sched #(.WIDTH(8)) dut (
        .CP    (CP),
        .CR    (CR),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .tick  (tick),
        .abort (abort),
        .gnt   (gnt),
        .busy  (busy),
        .cnt   (cnt),
        .done  (done)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Advance one edge and settle; outputs are sampled 1 time unit after posedge.
    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset();
        CR = 1'b1; req = 2'b00; abort = 1'b0; tick = 1'b1;
        step();
        step();
        CR = 1'b0;
    endtask

    task automatic test_reset();
        CR = 1'b1; req = 2'b11; abort = 1'b0; tick = 1'b1; len0 = 8'd3; len1 = 8'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({gnt, done, busy, cnt} !== 13'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d gnt=%b done=%b busy=%b cnt=%0d expected all 0", i, gnt, done, busy, cnt);
            end
        end
        CR = 1'b0;
        step();
        n_cmp++;
        if (gnt !== 2'b01 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release gnt=%b busy=%b expected gnt=01 busy=1", gnt, busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_cnt;
        do_reset();
        req = 2'b01; len0 = 8'd3; tick = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 2'b01 || busy !== 1'b1 || done !== 2'b00) begin
            n_err++;
            $display("FAIL single_load gnt=%b busy=%b done=%b expected 01/1/00", gnt, busy, done);
        end
        exp_cnt = 8'd253;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (cnt !== exp_cnt || done !== 2'b00) begin
                n_err++;
                $display("FAIL single_run cnt=%0d done=%b expected cnt=%0d done=00", cnt, done, exp_cnt);
            end
            exp_cnt = exp_cnt + 8'd1;
        end
        step();
        n_cmp++;
        if (done !== 2'b01 || gnt !== 2'b01 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL single_done done=%b gnt=%b cnt=%0d expected 01/01/0", done, gnt, cnt);
        end
        req = 2'b00;
        step();
        n_cmp++;
        if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle gnt=%b done=%b busy=%b expected 00/00/0", gnt, done, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        req = 2'b11; len0 = 8'd2; len1 = 8'd2; tick = 1'b1;
        exp_g = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (gnt !== exp_g) begin
                n_err++;
                $display("FAIL rr_grant k=%0d gnt=%b expected %b", k, gnt, exp_g);
            end
            step();
            step();
            step();
            n_cmp++;
            if (done !== exp_g || gnt !== exp_g) begin
                n_err++;
                $display("FAIL rr_done k=%0d done=%b gnt=%b expected %b", k, done, gnt, exp_g);
            end
            step();
            n_cmp++;
            if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
                n_err++;
                $display("FAIL rr_gap k=%0d gnt=%b busy=%b done=%b expected idle", k, gnt, busy, done);
            end
            exp_g = {exp_g[0], exp_g[1]};
        end
    endtask

    task automatic test_tick_gating();
        logic [7:0] exp_cnt;
        logic       seen;
        do_reset();
        req = 2'b10; len1 = 8'd4; len0 = 8'd0; tick = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 2'b10) begin
            n_err++;
            $display("FAIL tick_grant gnt=%b expected 10", gnt);
        end
        len1 = 8'd9;
        step();
        n_cmp++;
        if (cnt !== 8'd252) begin
            n_err++;
            $display("FAIL tick_load cnt=%0d expected 252", cnt);
        end
        exp_cnt = 8'd252;
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            tick = (i % 3 == 2);
            step();
            n_cmp++;
            if (tick && exp_cnt == 8'd255) begin
                seen = 1'b1;
                if (done !== 2'b10 || cnt !== 8'd0) begin
                    n_err++;
                    $display("FAIL tick_done i=%0d done=%b cnt=%0d expected 10/0", i, done, cnt);
                end
            end else begin
                if (tick) exp_cnt = exp_cnt + 8'd1;
                if (done !== 2'b00 || cnt !== exp_cnt) begin
                    n_err++;
                    $display("FAIL tick_step i=%0d done=%b cnt=%0d expected 00/%0d", i, done, cnt, exp_cnt);
                end
            end
        end
        req = 2'b00; tick = 1'b1;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        req = 2'b01; len0 = 8'd5; len1 = 8'd5; tick = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (cnt !== 8'd254 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre cnt=%0d busy=%b expected 254/1", cnt, busy);
        end
        abort = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 2'b00 || cnt !== 8'd0 || done !== 2'b00) begin
            n_err++;
            $display("FAIL abort_idle busy=%b gnt=%b cnt=%0d done=%b expected 0/00/0/00", busy, gnt, cnt, done);
        end
        abort = 1'b0; req = 2'b11;
        step();
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_err++;
            $display("FAIL abort_regrant gnt=%b expected 01", gnt);
        end
        req = 2'b10;
        step();
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) begin
            n_err++;
            $display("FAIL reqdrop_idle busy=%b gnt=%b done=%b expected 0/00/00", busy, gnt, done);
        end
        step();
        n_cmp++;
        if (gnt !== 2'b10) begin
            n_err++;
            $display("FAIL reqdrop_next gnt=%b expected 10", gnt);
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_edge_len();
        do_reset();
        req = 2'b01; len0 = 8'd0; tick = 1'b1;
        step();
        step();
        n_cmp++;
        if (done !== 2'b01 || cnt !== 8'd0 || gnt !== 2'b01) begin
            n_err++;
            $display("FAIL len0_done done=%b cnt=%0d gnt=%b expected 01/0/01", done, cnt, gnt);
        end
        len0 = 8'd1;
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 2'b00) begin
            n_err++;
            $display("FAIL len0_idle busy=%b done=%b expected 0/00", busy, done);
        end
        step();
        step();
        n_cmp++;
        if (cnt !== 8'd255 || done !== 2'b00) begin
            n_err++;
            $display("FAIL len1_run cnt=%0d done=%b expected 255/00", cnt, done);
        end
        step();
        n_cmp++;
        if (done !== 2'b01 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL len1_done done=%b cnt=%0d expected 01/0", done, cnt);
        end
        len0 = 8'd200;
        step();
        step();
        step();
        step();
        n_cmp++;
        if (cnt !== 8'd57 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_pre cnt=%0d busy=%b expected 57/1", cnt, busy);
        end
        CR = 1'b1;
        step();
        n_cmp++;
        if ({gnt, done, busy, cnt} !== 13'd0) begin
            n_err++;
            $display("FAIL midrun_reset gnt=%b done=%b busy=%b cnt=%0d expected all 0", gnt, done, busy, cnt);
        end
        CR = 1'b0; req = 2'b00;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        CR = 1'b1; req = 2'b00; len0 = 8'd0; len1 = 8'd0; tick = 1'b0; abort = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_tick_gating();
        test_abort();
        test_edge_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
